// File: rtl/seq_divider_if.sv
// seq_divider_if: start/done handshake and operand/result bus of the iterative divider.
interface seq_divider_if #(
  parameter int unsigned WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  // Controller side: issues requests, observes results.
  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  // Divider side.
  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/seq_divider.sv
// seq_divider: radix-2 restoring divider, one quotient bit per clock.
// Optional feature: define SEQ_DIVIDER_SIGNED_EN for two's-complement operands
// (truncation toward zero); otherwise the unit is unsigned only.
module seq_divider #(
  parameter int unsigned WIDTH = 8
) (
  input logic          clk,
  input logic          rst_n,
  seq_divider_if.slave bus
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e            state_q, state_d;
  // Partial remainder is kept WIDTH bits wide: it is always below the divisor,
  // so the extra bit of the (WIDTH+1)-bit remainder is zero between steps.
  logic [WIDTH-1:0]  r_q, r_d;
  logic [WIDTH-1:0]  q_q, q_d;
  logic [WIDTH-1:0]  dvs_q, dvs_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]  quo_q, quo_d;
  logic [WIDTH-1:0]  rem_q, rem_d;
  logic              dz_q, dz_d;

  logic [WIDTH:0]    shifted;
  logic [WIDTH:0]    trial;
  logic [WIDTH-1:0]  step_r;
  logic [WIDTH-1:0]  step_q;
  logic [WIDTH-1:0]  fin_q;
  logic [WIDTH-1:0]  fin_r;
  logic [WIDTH-1:0]  dvd_load;
  logic [WIDTH-1:0]  dvs_load;

`ifdef SEQ_DIVIDER_SIGNED_EN
  logic              dvd_neg_q, dvd_neg_d;
  logic              sgn_diff_q, sgn_diff_d;
`endif

  // One restoring step: shift {R,Q}, trial-subtract, keep or restore.
  always_comb begin
    shifted = {r_q, q_q[WIDTH-1]};
    trial   = shifted - {1'b0, dvs_q};
    step_r  = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
    step_q  = {q_q[WIDTH-2:0], ~trial[WIDTH]};
  end

  // Operand magnitudes at load and sign fix-up of the final step.
  always_comb begin
`ifdef SEQ_DIVIDER_SIGNED_EN
    dvd_load = bus.dividend[WIDTH-1] ? -bus.dividend : bus.dividend;
    dvs_load = bus.divisor[WIDTH-1] ? -bus.divisor : bus.divisor;
    fin_q    = sgn_diff_q ? -step_q : step_q;
    fin_r    = dvd_neg_q ? -step_r : step_r;
`else
    dvd_load = bus.dividend;
    dvs_load = bus.divisor;
    fin_q    = step_q;
    fin_r    = step_r;
`endif
  end

  // Next-state and datapath control.
  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    q_d     = q_q;
    dvs_d   = dvs_q;
    cnt_d   = cnt_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dz_d    = dz_q;
`ifdef SEQ_DIVIDER_SIGNED_EN
    dvd_neg_d  = dvd_neg_q;
    sgn_diff_d = sgn_diff_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          if (bus.divisor == '0) begin
            quo_d   = '1;
            rem_d   = bus.dividend;
            dz_d    = 1'b1;
            state_d = StDone;
          end else begin
            r_d     = '0;
            q_d     = dvd_load;
            dvs_d   = dvs_load;
            cnt_d   = CntW'(WIDTH);
            state_d = StRun;
`ifdef SEQ_DIVIDER_SIGNED_EN
            dvd_neg_d  = bus.dividend[WIDTH-1];
            sgn_diff_d = bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1];
`endif
          end
        end
      end
      StRun: begin
        r_d   = step_r;
        q_d   = step_q;
        cnt_d = cnt_q - 1'b1;
        // Results are registered on the edge entering DONE so they are valid with done.
        if (cnt_q == CntW'(1)) begin
          quo_d   = fin_q;
          rem_d   = fin_r;
          dz_d    = 1'b0;
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State, datapath and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      r_q     <= '0;
      q_q     <= '0;
      dvs_q   <= '0;
      cnt_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      dz_q    <= 1'b0;
`ifdef SEQ_DIVIDER_SIGNED_EN
      dvd_neg_q  <= 1'b0;
      sgn_diff_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      q_q     <= q_d;
      dvs_q   <= dvs_d;
      cnt_q   <= cnt_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dz_q    <= dz_d;
`ifdef SEQ_DIVIDER_SIGNED_EN
      dvd_neg_q  <= dvd_neg_d;
      sgn_diff_q <= sgn_diff_d;
`endif
    end
  end

  // Status decodes straight from the state register.
  always_comb begin
    bus.busy        = (state_q == StRun);
    bus.done        = (state_q == StDone);
    bus.quotient    = quo_q;
    bus.remainder   = rem_q;
    bus.div_by_zero = dz_q;
  end

endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: table vectors, hand-written handshake corner cases and random
// stimulus against a plain-arithmetic reference model.
module tb_seq_divider;
  localparam int unsigned W = 8;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dz;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  seq_divider_if #(.WIDTH(W)) bus_if ();

  seq_divider #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  // Reference: quotient/remainder by the language's own division operators.
  function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [W-1:0] q, output logic [W-1:0] r,
                                output logic dz);
    int sa;
    int sb;
    sa = int'($signed(a));
    sb = int'($signed(b));
    if (b == '0) begin
      q  = '1;
      r  = a;
      dz = 1'b1;
    end else begin
`ifdef SEQ_DIVIDER_SIGNED_EN
      q = W'(sa / sb);
      r = W'(sa % sb);
`else
      q = a / b;
      r = a % b;
`endif
      dz = 1'b0;
    end
  endfunction

  // One division from IDLE; poke>0 pulses start with other operands in that busy cycle.
  task automatic run_div(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] eq, input logic [W-1:0] er, input logic edz,
                         input int poke);
    int           lat;
    int           nbusy;
    logic         busy_at_done;
    logic [W-1:0] gq;
    logic [W-1:0] gr;
    logic         gdz;
    lat          = 0;
    nbusy        = 0;
    busy_at_done = 1'b0;
    gq           = '0;
    gr           = '0;
    gdz          = 1'b0;
    @(negedge clk);
    bus_if.dividend = a;
    bus_if.divisor  = b;
    bus_if.start    = 1'b1;
    @(negedge clk);
    bus_if.start    = 1'b0;
    // Operands must already be captured; scramble the inputs.
    bus_if.dividend = ~a;
    bus_if.divisor  = b ^ 8'h5a;
    for (int i = 1; i <= 40; i++) begin
      if (bus_if.busy) nbusy++;
      if (bus_if.done) begin
        lat          = i;
        busy_at_done = bus_if.busy;
        gq           = bus_if.quotient;
        gr           = bus_if.remainder;
        gdz          = bus_if.div_by_zero;
        break;
      end
      bus_if.start = (poke != 0 && i == poke);
      @(negedge clk);
    end
    bus_if.start = 1'b0;
    check({tag, " latency"}, lat, (b == '0) ? 1 : W + 1);
    check({tag, " busy cycles"}, nbusy, (b == '0) ? 0 : W);
    check({tag, " busy during done"}, busy_at_done, 1'b0);
    check({tag, " quotient"}, gq, eq);
    check({tag, " remainder"}, gr, er);
    check({tag, " div_by_zero"}, gdz, edz);
    @(negedge clk);
    check({tag, " done single pulse"}, bus_if.done, 1'b0);
    check({tag, " quotient held"}, bus_if.quotient, eq);
  endtask

  initial begin
    vec_t         vecs [9];
    logic [W-1:0] ma;
    logic [W-1:0] mb;
    logic [W-1:0] mq;
    logic [W-1:0] mr;
    logic         mdz;
    logic [W-1:0] q1;
    logic [W-1:0] r1;
    int           d1;
    int           d2;
    int           ndone;
    int           poke;

`ifdef SEQ_DIVIDER_SIGNED_EN
    vecs[0] = '{8'hf9, 8'h02, 8'hfd, 8'hff, 1'b0};
    vecs[1] = '{8'h80, 8'hff, 8'h80, 8'h00, 1'b0};
    vecs[2] = '{8'h64, 8'h07, 8'h0e, 8'h02, 1'b0};
    vecs[3] = '{8'h05, 8'h00, 8'hff, 8'h05, 1'b1};
    vecs[4] = '{8'h07, 8'hfe, 8'hfd, 8'h01, 1'b0};
    vecs[5] = '{8'hf9, 8'hfe, 8'h03, 8'hff, 1'b0};
    vecs[6] = '{8'h7f, 8'h01, 8'h7f, 8'h00, 1'b0};
    vecs[7] = '{8'h80, 8'h00, 8'hff, 8'h80, 1'b1};
    vecs[8] = '{8'h80, 8'h02, 8'hc0, 8'h00, 1'b0};
`else
    vecs[0] = '{8'd100, 8'd7, 8'd14, 8'd2, 1'b0};
    vecs[1] = '{8'd5, 8'd0, 8'd255, 8'd5, 1'b1};
    vecs[2] = '{8'd255, 8'd1, 8'd255, 8'd0, 1'b0};
    vecs[3] = '{8'd3, 8'd200, 8'd0, 8'd3, 1'b0};
    vecs[4] = '{8'd0, 8'd5, 8'd0, 8'd0, 1'b0};
    vecs[5] = '{8'd200, 8'd200, 8'd1, 8'd0, 1'b0};
    vecs[6] = '{8'd7, 8'd100, 8'd0, 8'd7, 1'b0};
    vecs[7] = '{8'd128, 8'd3, 8'd42, 8'd2, 1'b0};
    vecs[8] = '{8'd255, 8'd255, 8'd1, 8'd0, 1'b0};
`endif

    bus_if.start    = 1'b0;
    bus_if.dividend = '0;
    bus_if.divisor  = '0;
    #2;
    check("reset busy", bus_if.busy, 1'b0);
    check("reset done", bus_if.done, 1'b0);
    check("reset quotient", bus_if.quotient, 0);
    check("reset remainder", bus_if.remainder, 0);
    check("reset div_by_zero", bus_if.div_by_zero, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      run_div($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r,
              vecs[i].dz, 0);
    end

    // Start ignored while busy: result must come from the original operands.
    model(8'd100, 8'd7, mq, mr, mdz);
    run_div("poke", 8'd100, 8'd7, mq, mr, mdz, 3);

    // Back-to-back with start held high: second accept only after done + one IDLE cycle.
    @(negedge clk);
    bus_if.dividend = 8'd255;
    bus_if.divisor  = 8'd1;
    bus_if.start    = 1'b1;
    @(negedge clk);
    bus_if.dividend = 8'd3;
    bus_if.divisor  = 8'd200;
    d1    = 0;
    d2    = 0;
    ndone = 0;
    q1    = '0;
    r1    = '0;
    for (int i = 1; i <= 60; i++) begin
      if (bus_if.done) begin
        ndone++;
        if (ndone == 1) begin
          d1 = i;
          q1 = bus_if.quotient;
          r1 = bus_if.remainder;
        end else begin
          d2 = i;
          break;
        end
      end
      @(negedge clk);
    end
    bus_if.start = 1'b0;
    model(8'd255, 8'd1, mq, mr, mdz);
    check("b2b first done cycle", d1, W + 1);
    check("b2b first quotient", q1, mq);
    check("b2b first remainder", r1, mr);
    check("b2b second done cycle", d2, 2 * W + 3);
    model(8'd3, 8'd200, mq, mr, mdz);
    check("b2b second quotient", bus_if.quotient, mq);
    check("b2b second remainder", bus_if.remainder, mr);
    @(negedge clk);
    @(negedge clk);

    // Leave a nonzero divide-by-zero result so the reset clear is observable.
    model(8'd9, 8'd0, mq, mr, mdz);
    run_div("dz before reset", 8'd9, 8'd0, mq, mr, mdz, 0);

    // Reset in the middle of RUN.
    @(negedge clk);
    bus_if.dividend = 8'd100;
    bus_if.divisor  = 8'd7;
    bus_if.start    = 1'b1;
    @(negedge clk);
    bus_if.start = 1'b0;
    repeat (3) @(negedge clk);
    check("pre-reset busy", bus_if.busy, 1'b1);
    rst_n = 1'b0;
    #1;
    check("mid reset busy", bus_if.busy, 1'b0);
    check("mid reset done", bus_if.done, 1'b0);
    check("mid reset quotient", bus_if.quotient, 0);
    check("mid reset remainder", bus_if.remainder, 0);
    check("mid reset div_by_zero", bus_if.div_by_zero, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    model(8'd200, 8'd9, mq, mr, mdz);
    run_div("after reset", 8'd200, 8'd9, mq, mr, mdz, 0);

    // Random operands, occasional zero divisor and ignored mid-run starts.
    for (int n = 0; n < 40; n++) begin
      ma = W'($urandom);
      mb = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
      poke = (mb != '0 && $urandom_range(0, 3) == 0) ? int'($urandom_range(1, W)) : 0;
      model(ma, mb, mq, mr, mdz);
      run_div($sformatf("rand%0d %0h/%0h", n, ma, mb), ma, mb, mq, mr, mdz, poke);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
